// File: rtl/dec_pkg.sv
// Shared decode definitions for decode_stage_pipe: opcodes, ALU and immediate
// selector encodings, and the bit layout of the out_ctrl bundle.
package dec_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    RD_ALU = 2'd0,
    RD_MEM = 2'd1,
    RD_PC4 = 2'd2
  } rd_sel_e;

  // out_ctrl bit positions, LSB first
  localparam int CTRL_W       = 11;
  localparam int CB_REG_WRITE = 0;
  localparam int CB_RD_SEL    = 1;
  localparam int CB_LOAD      = 3;
  localparam int CB_STORE     = 4;
  localparam int CB_BRANCH    = 5;
  localparam int CB_JAL       = 6;
  localparam int CB_JALR      = 7;
  localparam int CB_LUI       = 8;
  localparam int CB_AUIPC     = 9;
  localparam int CB_ILLEGAL   = 10;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_sel_e sel);
    logic [31:0] imm;
    case (sel)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch-side, writeback and ID/EX bundle of decode_stage_pipe.
// master = surrounding pipeline, slave = the decode stage.
interface decode_stage_pipe_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int RW = $clog2(NREGS);

  logic                        in_valid;
  logic                        in_ready;
  logic [31:0]                 in_instr;
  logic [XLEN-1:0]             in_pc;

  logic                        wb_en;
  logic [RW-1:0]               wb_rd;
  logic [XLEN-1:0]             wb_data;

  logic                        flush;

  logic                        out_valid;
  logic                        out_ready;
  logic [XLEN-1:0]             out_pc;
  logic [XLEN-1:0]             out_op_a;
  logic [XLEN-1:0]             out_op_b;
  logic [XLEN-1:0]             out_rs2_data;
  logic [XLEN-1:0]             out_imm;
  logic [RW-1:0]               out_rd;
  logic [2:0]                  out_fun3;
  logic [3:0]                  out_alu_ctrl;
  logic [dec_pkg::CTRL_W-1:0]  out_ctrl;

  modport master (
    output in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_op_a, out_op_b, out_rs2_data,
           out_imm, out_rd, out_fun3, out_alu_ctrl, out_ctrl
  );

  modport slave (
    input  in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, out_pc, out_op_a, out_op_b, out_rs2_data,
           out_imm, out_rd, out_fun3, out_alu_ctrl, out_ctrl
  );

endinterface

// File: rtl/dec_ctrl.sv
// Combinational RV32I decode of opcode/funct3/funct7[5] into the control
// bundle, ALU operation, immediate selector, operand selects and rs-used flags.
module dec_ctrl
  import dec_pkg::*;
(
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  output logic [CTRL_W-1:0] ctrl,
  output alu_op_e           alu_ctrl,
  output imm_sel_e          imm_sel,
  output logic              rs1_used,
  output logic              rs2_used,
  output logic              op_a_pc,
  output logic              op_a_zero,
  output logic              op_b_imm
);

  // funct7[5] selects SUB only for register ops; it is an immediate bit for addi
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt, input logic is_reg);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    ctrl      = '0;
    alu_ctrl  = ALU_ADD;
    imm_sel   = IMM_I;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    op_a_pc   = 1'b0;
    op_a_zero = 1'b0;
    op_b_imm  = 1'b1;
    case (opcode)
      OP_LUI: begin
        ctrl[CB_REG_WRITE] = 1'b1;
        ctrl[CB_LUI]       = 1'b1;
        imm_sel            = IMM_U;
        op_a_zero          = 1'b1;
      end
      OP_AUIPC: begin
        ctrl[CB_REG_WRITE] = 1'b1;
        ctrl[CB_AUIPC]     = 1'b1;
        imm_sel            = IMM_U;
        op_a_pc            = 1'b1;
      end
      OP_JAL: begin
        ctrl[CB_REG_WRITE]    = 1'b1;
        ctrl[CB_RD_SEL +: 2]  = RD_PC4;
        ctrl[CB_JAL]          = 1'b1;
        imm_sel               = IMM_J;
        op_a_pc               = 1'b1;
      end
      OP_JALR: begin
        ctrl[CB_REG_WRITE]    = 1'b1;
        ctrl[CB_RD_SEL +: 2]  = RD_PC4;
        ctrl[CB_JALR]         = 1'b1;
        rs1_used              = 1'b1;
      end
      OP_BRANCH: begin
        ctrl[CB_BRANCH] = 1'b1;
        imm_sel         = IMM_B;
        rs1_used        = 1'b1;
        rs2_used        = 1'b1;
        op_b_imm        = 1'b0;
        alu_ctrl        = ALU_SUB;
      end
      OP_LOAD: begin
        ctrl[CB_REG_WRITE]    = 1'b1;
        ctrl[CB_RD_SEL +: 2]  = RD_MEM;
        ctrl[CB_LOAD]         = 1'b1;
        rs1_used              = 1'b1;
      end
      OP_STORE: begin
        ctrl[CB_STORE] = 1'b1;
        imm_sel        = IMM_S;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OP_IMM: begin
        ctrl[CB_REG_WRITE] = 1'b1;
        rs1_used           = 1'b1;
        alu_ctrl           = arith_op(funct3, funct7_5, 1'b0);
      end
      OP_REG: begin
        ctrl[CB_REG_WRITE] = 1'b1;
        rs1_used           = 1'b1;
        rs2_used           = 1'b1;
        op_b_imm           = 1'b0;
        alu_ctrl           = arith_op(funct3, funct7_5, 1'b1);
      end
      OP_FENCE: begin
        // single-issue in-order core: fence decodes as a no-op
      end
      default: begin
        ctrl[CB_ILLEGAL] = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered RV32I decode stage: register file, RAW/WAW scoreboard, ID/EX register.
// Optional `DECODE_WB_BYPASS_EN forwards same-cycle writeback into operand reads.
module decode_stage_pipe
  import dec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic                 clk,
  input logic                 rst,
  decode_stage_pipe_if.slave  io
);
  localparam int RW = $clog2(NREGS);

  logic [XLEN-1:0]   rf [NREGS];
  logic [NREGS-1:0]  busy;

  logic [6:0]        opcode;
  logic [RW-1:0]     rs1;
  logic [RW-1:0]     rs2;
  logic [RW-1:0]     rd;
  logic [CTRL_W-1:0] ctrl;
  alu_op_e           alu_ctrl;
  imm_sel_e          imm_sel;
  logic              rs1_used;
  logic              rs2_used;
  logic              op_a_pc;
  logic              op_a_zero;
  logic              op_b_imm;

  logic [31:0]       imm32;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic              wb_hit_rs1;
  logic              wb_hit_rs2;
  logic              ex_writes;
  logic              rs1_haz;
  logic              rs2_haz;
  logic              waw_haz;
  logic              stall;
  logic              accept;
  logic              handoff;

  assign opcode = io.in_instr[6:0];
  assign rd     = io.in_instr[7 +: RW];
  assign rs1    = io.in_instr[15 +: RW];
  assign rs2    = io.in_instr[20 +: RW];

  dec_ctrl u_dec_ctrl (
    .opcode    (opcode),
    .funct3    (io.in_instr[14:12]),
    .funct7_5  (io.in_instr[30]),
    .ctrl      (ctrl),
    .alu_ctrl  (alu_ctrl),
    .imm_sel   (imm_sel),
    .rs1_used  (rs1_used),
    .rs2_used  (rs2_used),
    .op_a_pc   (op_a_pc),
    .op_a_zero (op_a_zero),
    .op_b_imm  (op_b_imm)
  );

  assign imm32 = imm_gen(io.in_instr, imm_sel);
  assign imm   = XLEN'($signed(imm32));

  always_comb begin
    rs1_data = (rs1 == '0) ? '0 : rf[rs1];
    rs2_data = (rs2 == '0) ? '0 : rf[rs2];
`ifdef DECODE_WB_BYPASS_EN
    wb_hit_rs1 = io.wb_en && (io.wb_rd == rs1) && (rs1 != '0);
    wb_hit_rs2 = io.wb_en && (io.wb_rd == rs2) && (rs2 != '0);
    if (wb_hit_rs1) rs1_data = io.wb_data;
    if (wb_hit_rs2) rs2_data = io.wb_data;
`else
    wb_hit_rs1 = 1'b0;
    wb_hit_rs2 = 1'b0;
`endif
  end

  always_comb begin
    op_a = rs1_data;
    if (op_a_zero)    op_a = '0;
    else if (op_a_pc) op_a = io.in_pc;
    op_b = op_b_imm ? imm : rs2_data;
  end

  // The ID/EX entry is a writer not yet in the scoreboard; it counts as
  // pending for both RAW and WAW so one register never has two writers in flight.
  assign ex_writes = io.out_valid && io.out_ctrl[CB_REG_WRITE];

  assign rs1_haz = rs1_used && (rs1 != '0) &&
                   ((busy[rs1] && !wb_hit_rs1) || (ex_writes && (io.out_rd == rs1)));
  assign rs2_haz = rs2_used && (rs2 != '0) &&
                   ((busy[rs2] && !wb_hit_rs2) || (ex_writes && (io.out_rd == rs2)));
  assign waw_haz = ctrl[CB_REG_WRITE] && (rd != '0) &&
                   (busy[rd] || (ex_writes && (io.out_rd == rd)));

  assign stall       = rs1_haz || rs2_haz || waw_haz;
  assign io.in_ready = !stall && (!io.out_valid || io.out_ready);
  assign accept      = io.in_valid && io.in_ready;
  assign handoff     = io.out_valid && io.out_ready && !io.flush &&
                       io.out_ctrl[CB_REG_WRITE] && (io.out_rd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (io.wb_en && (io.wb_rd != '0)) begin
      rf[io.wb_rd] <= io.wb_data;
    end
  end

  // Set is applied after clear so a same-edge set/clear on one register leaves it busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (io.wb_en) busy[io.wb_rd] <= 1'b0;
      if (handoff)  busy[io.out_rd] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io.out_valid    <= 1'b0;
      io.out_pc       <= '0;
      io.out_op_a     <= '0;
      io.out_op_b     <= '0;
      io.out_rs2_data <= '0;
      io.out_imm      <= '0;
      io.out_rd       <= '0;
      io.out_fun3     <= '0;
      io.out_alu_ctrl <= '0;
      io.out_ctrl     <= '0;
    end else if (io.flush) begin
      io.out_valid <= 1'b0;
    end else if (accept) begin
      io.out_valid    <= 1'b1;
      io.out_pc       <= io.in_pc;
      io.out_op_a     <= op_a;
      io.out_op_b     <= op_b;
      io.out_rs2_data <= rs2_data;
      io.out_imm      <= imm;
      io.out_rd       <= rd;
      io.out_fun3     <= io.in_instr[14:12];
      io.out_alu_ctrl <= alu_ctrl;
      io.out_ctrl     <= ctrl;
    end else if (io.out_ready) begin
      io.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: hazards, backpressure, flush, x0,
// illegal opcode and asynchronous reset, with hand-computed expectations.
module tb_decode_stage_pipe;

  localparam logic [31:0] ADDI_X1_5   = 32'h00500093;
  localparam logic [31:0] ADD_X2_X1   = 32'h00108133;
  localparam logic [31:0] LUI_X8      = 32'h12345437;
  localparam logic [31:0] ADDI_X3_7   = 32'h00700193;
  localparam logic [31:0] ADDI_X10_M3 = 32'hFFD00513;
  localparam logic [31:0] ADDI_X5_X3  = 32'h00118293;
  localparam logic [31:0] LW_X0       = 32'h00002003;
  localparam logic [31:0] ADD_X11_X0  = 32'h000005B3;
  localparam logic [31:0] JAL_X9_16   = 32'h010004EF;
  localparam logic [31:0] ILLEGAL_OP  = 32'h0000007F;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_pipe_if #(.XLEN(32), .NREGS(32)) io ();

  decode_stage_pipe #(.XLEN(32), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    io.in_valid = 1'b1;
    io.in_instr = instr;
    io.in_pc    = pc;
    #1;
  endtask

  task automatic chk_entry(input string tag, input logic [31:0] pc, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [10:0] ctrl);
    check({tag, ".valid"}, io.out_valid, 1);
    check({tag, ".pc"},    io.out_pc, pc);
    check({tag, ".op_a"},  io.out_op_a, a);
    check({tag, ".op_b"},  io.out_op_b, b);
    check({tag, ".rd"},    io.out_rd, rd);
    check({tag, ".ctrl"},  io.out_ctrl, ctrl);
  endtask

  initial begin
    rst          = 1'b0;
    io.in_valid  = 1'b0;
    io.in_instr  = '0;
    io.in_pc     = '0;
    io.wb_en     = 1'b0;
    io.wb_rd     = '0;
    io.wb_data   = '0;
    io.flush     = 1'b0;
    io.out_ready = 1'b1;

    #3;
    check("rst.valid", io.out_valid, 0);
    check("rst.op_a",  io.out_op_a, 0);
    check("rst.op_b",  io.out_op_b, 0);
    check("rst.pc",    io.out_pc, 0);
    check("rst.ctrl",  io.out_ctrl, 0);
    check("rst.ready", io.in_ready, 1);
    tick();
    rst = 1'b1;

    present(ADDI_X1_5, 32'h100);
    check("addi.ready", io.in_ready, 1);
    tick();
    chk_entry("addi", 32'h100, 0, 5, 1, 11'h001);
    check("addi.alu", io.out_alu_ctrl, 0);
    check("addi.imm", io.out_imm, 5);

    // add x2,x1,x1 stalls on the unhanded ID/EX writer, then on busy[1]
    present(ADD_X2_X1, 32'h104);
    check("raw.ex", io.in_ready, 0);
    tick();
    check("raw.handoff", io.out_valid, 0);
    check("raw.busy", io.in_ready, 0);
    io.wb_en   = 1'b1;
    io.wb_rd   = 5'd1;
    io.wb_data = 32'd5;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    check("raw.wbcycle", io.in_ready, 1);
    tick();
    io.wb_en = 1'b0;
`else
    check("raw.wbcycle", io.in_ready, 0);
    tick();
    io.wb_en = 1'b0;
    #1;
    check("raw.bubble.valid", io.out_valid, 0);
    check("raw.after", io.in_ready, 1);
    tick();
`endif
    chk_entry("add", 32'h104, 5, 5, 2, 11'h001);
    check("add.rs2", io.out_rs2_data, 5);

    // backpressure: entry frozen for 3 cycles
    io.out_ready = 1'b0;
    present(LUI_X8, 32'h108);
    check("bp.ready0", io.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_entry("bp.hold", 32'h104, 5, 5, 2, 11'h001);
      check("bp.ready", io.in_ready, 0);
    end
    io.out_ready = 1'b1;
    #1;
    check("bp.release", io.in_ready, 1);
    tick();
    chk_entry("lui", 32'h108, 0, 32'h12345000, 8, 11'h101);
    check("lui.imm", io.out_imm, 32'h12345000);

    present(ADDI_X3_7, 32'h10C);
    check("addi3.ready", io.in_ready, 1);
    tick();
    chk_entry("addi3", 32'h10C, 0, 7, 3, 11'h001);

    // flush kills the x3 writer and drops the concurrently accepted addi x10
    io.flush = 1'b1;
    present(ADDI_X10_M3, 32'h110);
    check("flush.ready", io.in_ready, 1);
    tick();
    io.flush = 1'b0;
    check("flush.valid", io.out_valid, 0);
    present(ADDI_X5_X3, 32'h114);
    check("flush.nostall", io.in_ready, 1);
    tick();
    chk_entry("x3read", 32'h114, 0, 1, 5, 11'h001);

    present(ADDI_X10_M3, 32'h118);
    tick();
    chk_entry("neg", 32'h118, 0, 32'hFFFFFFFD, 10, 11'h001);
    check("neg.imm", io.out_imm, 32'hFFFFFFFD);

    // x0: a write of 0xDEADBEEF is ignored and lw x0 never marks x0 busy
    io.wb_en   = 1'b1;
    io.wb_rd   = 5'd0;
    io.wb_data = 32'hDEADBEEF;
    present(LW_X0, 32'h11C);
    check("lw0.ready", io.in_ready, 1);
    tick();
    io.wb_en = 1'b0;
    chk_entry("lw0", 32'h11C, 0, 0, 0, 11'h00B);
    present(ADD_X11_X0, 32'h120);
    check("x0.nostall", io.in_ready, 1);
    tick();
    chk_entry("x0read", 32'h120, 0, 0, 11, 11'h001);

    present(JAL_X9_16, 32'h200);
    tick();
    chk_entry("jal", 32'h200, 32'h200, 16, 9, 11'h045);
    check("jal.imm", io.out_imm, 16);

    present(ILLEGAL_OP, 32'h300);
    tick();
    check("ill.valid", io.out_valid, 1);
    check("ill.pc",    io.out_pc, 32'h300);
    check("ill.ctrl",  io.out_ctrl, 11'h400);

    // WAW on busy[2], then asynchronous reset in the middle of the stall
    io.out_ready = 1'b0;
    present(ADD_X2_X1, 32'h304);
    check("waw.bp", io.in_ready, 0);
    io.out_ready = 1'b1;
    #1;
    check("waw.busy", io.in_ready, 0);
    #1;
    rst = 1'b0;
    #1;
    check("arst.valid", io.out_valid, 0);
    check("arst.ctrl",  io.out_ctrl, 0);
    check("arst.pc",    io.out_pc, 0);
    check("arst.ready", io.in_ready, 1);
    tick();
    rst = 1'b1;
    #1;
    check("arst.release", io.in_ready, 1);
    tick();
    chk_entry("postrst", 32'h304, 0, 0, 2, 11'h001);
    io.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised, registered successor to the single-cycle decode stage for the pipelined RV32I core. It sits between fetch and execute and accepts one instruction per cycle through a valid/ready handshake. It reads an internal register file, generates the immediate and control bundle, and presents them in an ID/EX output register. A per-register scoreboard stalls RAW and WAW hazards against in-flight writers until their writeback returns.

## Interface
Parameters:
- XLEN, 32: datapath width.
- NREGS, 32: architectural register count (16 for RV32E); RW = $clog2(NREGS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- wb_en  in  1  writeback strobe.
- wb_rd  in  RW  writeback destination.
- wb_data  in  XLEN  writeback value.
- flush  in  1  kill the ID/EX entry and the current input.
- out_valid  out  1  ID/EX entry valid.
- out_ready  in  1  execute accepts the entry.
- out_pc  out  XLEN  PC of the entry.
- out_op_a  out  XLEN  operand A: rs1 data, or PC when auipc/jal.
- out_op_b  out  XLEN  operand B: rs2 data or the selected immediate.
- out_rs2_data  out  XLEN  raw rs2 data, used for stores and branch compare.
- out_imm  out  XLEN  selected immediate (I/S/B/J/U).
- out_rd  out  RW  destination register.
- out_fun3  out  3  funct3 passthrough.
- out_alu_ctrl  out  4  ALU operation.
- out_ctrl  out  CTRL_W  bundle: reg_write, rd_sel[1:0], load, store, branch, jal, jalr, lui, auipc, illegal.

## Operation
- Accept condition: in_valid && in_ready. in_ready = !stall && (!out_valid || out_ready).
- stall is asserted when either of these holds:
  - an rs1/rs2 field used by the opcode hits a busy scoreboard bit, or hits out_rd of a valid ID/EX entry with reg_write set;
  - the instruction writes an rd that is busy (WAW).
- x0 is never busy, always reads 0, and ignores writes.
- Scoreboard:
  - busy[out_rd] is set on ID/EX handoff (out_valid && out_ready && reg_write).
  - busy[wb_rd] is cleared on wb_en.
  - If set and clear hit the same register on the same edge, set wins.
- Register file: written on the edge when wb_en is high and wb_rd != 0.
- Illegal opcode: illegal=1, reg_write=0, load=0, store=0, branch=0. The entry is still issued so execute can trap.
- Output register holds every field stable while out_valid && !out_ready.
- flush:
  - On the next edge out_valid becomes 0 and any concurrently accepted input is dropped.
  - The scoreboard is unaffected, because a killed entry was never handed off.
  - in_ready stays computed as normal; the fetch side discards on its own flush.

## Timing
- Latency: accepted at edge N, visible with out_valid=1 after edge N.
- Throughput: 1 instruction/cycle absent stalls and backpressure.
- Without bypass, a consumer of wb_rd stalls through the wb cycle and reads the new value the next cycle (1-cycle bubble after writeback).
- Reset (rst=0, asynchronous):
  - out_valid=0 and all out_* = 0.
  - All registers = 0 and the scoreboard is clear.
  - in_ready follows its equation, so it is 1 while rst=0.
- Reset mid-stall discards the pending entry; there is no replay.

## Configuration
- DECODE_WB_BYPASS_EN defined: a same-cycle wb_en match on rs1/rs2 clears that hazard, and wb_data is forwarded into operand selection. No bubble after writeback.
- DECODE_WB_BYPASS_EN undefined: no forwarding. Hazard clears one cycle after writeback.

## Structure
- Package dec_pkg holds:
  - opcode constants;
  - ALU control encodings;
  - imm_sel encodings;
  - CTRL_W and the bit-index localparams of out_ctrl.
- One sub-module, dec_ctrl: purely combinational decode of opcode/funct3/funct7[5] into the control bundle, alu_ctrl, imm_sel and rs-used flags. The register file, scoreboard and ID/EX register stay in the top.

## Test plan
- Reset release, then addi x1,x0,5 with in_valid=1 and out_ready=1 -> out_valid=1 after one edge; out_op_a=0, out_op_b=5, out_rd=1, reg_write=1, alu_ctrl=ADD.
- addi x1 followed by add x2,x1,x1:
  - expected: add stalls (in_ready=0) until wb_en with wb_rd=1 and wb_data=5;
  - bypass off: add issues one cycle later with op_a=op_b=5;
  - bypass on: add issues on the wb cycle with forwarded 5.
- out_ready=0 for 3 cycles with a valid entry -> all outputs unchanged, in_ready=0; first cycle of out_ready=1 accepts the next instruction.
- flush while the ID/EX entry holds a writer of x3 and a new instruction is presented -> out_valid=0 next cycle, busy[3]=0, and a following read of x3 issues with no stall.
- lw x0 and writes via wb_rd=0, wb_data=0xDEADBEEF -> x0 still reads 0, no stall on rs1=x0.
- Opcode 7'b1111111 -> illegal=1, reg_write=0, entry issued; assert rst low mid-stall -> out_valid=0 and scoreboard clear immediately.
